// File: rtl/my_cpu_ctrl_if.sv
// Bundles the controller's instruction-memory, data-memory and ALU signals.
// master = controller side; slave = memories plus the combinational ALU.
interface my_cpu_ctrl_if;
    logic [15:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [14:0] pc;
    logic [15:0] in_m;
    logic        m_ready;
    logic [14:0] address_m;
    logic [15:0] out_m;
    logic        write_m;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        zx, nx, zy, ny, f, no;
    logic [15:0] alu_out;
    logic        zr, ng;

    modport master (
        input  inst, inst_valid, in_m, m_ready, alu_out, zr, ng,
        output inst_ready, pc, address_m, out_m, write_m, alu_x, alu_y,
               zx, nx, zy, ny, f, no
    );

    modport slave (
        output inst, inst_valid, in_m, m_ready, alu_out, zr, ng,
        input  inst_ready, pc, address_m, out_m, write_m, alu_x, alu_y,
               zx, nx, zy, ny, f, no
    );
endinterface

// File: rtl/my_cpu_ctrl.sv
// Hack-style fetch/execute controller: holds A/D/PC/IR and steers an external ALU.
// Latency: 2 cycles per instruction (accept, retire), plus one per m_ready=0 cycle on memory ops.
// Backpressure: inst_ready only in FETCH; memory ops stall in EXEC until m_ready.
module my_cpu_ctrl (
    input  logic          clk,
    input  logic          reset,
    my_cpu_ctrl_if.master bus
);
    typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [15:0] a_q, d_q, ir_q;
    logic [14:0] pc_q;
    logic        is_c, needs_mem, retire, take;

    assign is_c      = (state == EXEC) && ir_q[15];
    assign needs_mem = is_c && (ir_q[12] || ir_q[3]);
    assign retire    = (state == EXEC) && (!needs_mem || bus.m_ready);
    assign take      = (ir_q[2] & bus.ng) | (ir_q[1] & bus.zr) |
                       (ir_q[0] & ~bus.ng & ~bus.zr);

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.inst_ready = 1'b0;
        bus.pc         = pc_q;
        bus.address_m  = a_q[14:0];
        bus.out_m      = bus.alu_out;
        bus.write_m    = 1'b0;
        bus.alu_x      = d_q;
        bus.alu_y      = a_q;
        {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = 6'd0;
        case (state)
            FETCH: begin
                bus.inst_ready = 1'b1;
                if (bus.inst_valid) state_nxt = EXEC;
            end
            EXEC: begin
                if (is_c) begin
                    bus.write_m = ir_q[3];
                    bus.alu_y   = ir_q[12] ? bus.in_m : a_q;
                    {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = ir_q[11:6];
                end
                if (retire) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // The jump target reads a_q before this edge's A writeback lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= 16'd0;
            d_q  <= 16'd0;
            ir_q <= 16'd0;
            pc_q <= 15'd0;
        end else begin
            if (state == FETCH && bus.inst_valid) ir_q <= bus.inst;
            if (retire) begin
                if (!ir_q[15]) begin
                    a_q  <= {1'b0, ir_q[14:0]};
                    pc_q <= pc_q + 15'd1;
                end else begin
                    if (ir_q[5]) a_q <= bus.alu_out;
                    if (ir_q[4]) d_q <= bus.alu_out;
                    pc_q <= take ? a_q[14:0] : pc_q + 15'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_my_cpu_ctrl.sv
// Directed and randomized bench for my_cpu_ctrl with an instruction-level reference model.
module tb_my_cpu_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    my_cpu_ctrl_if bus();
    my_cpu_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic logic [15:0] alu_f(input logic [15:0] x, input logic [15:0] y,
                                          input logic [5:0] c);
        logic [15:0] xx, yy, r;
        xx = c[5] ? 16'h0 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0 : y;
        if (c[2]) yy = ~yy;
        r = c[1] ? xx + yy : xx & yy;
        if (c[0]) r = ~r;
        return r;
    endfunction

    assign bus.alu_out = alu_f(bus.alu_x, bus.alu_y,
                               {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no});
    assign bus.zr = (bus.alu_out == 16'h0);
    assign bus.ng = bus.alu_out[15];

    int checks = 0;
    int errors = 0;
    logic [15:0] m_a, m_d;
    logic [14:0] m_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_rdy"}, 32'(bus.inst_ready), 1);
        chk({tag, "_pc"}, 32'(bus.pc), 32'(m_pc));
        chk({tag, "_wr"}, 32'(bus.write_m), 0);
        chk({tag, "_x"}, 32'(bus.alu_x), 32'(m_d));
        chk({tag, "_y"}, 32'(bus.alu_y), 32'(m_a));
        chk({tag, "_addr"}, 32'(bus.address_m), 32'(m_a[14:0]));
        chk({tag, "_ctl"}, 32'({bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no}), 0);
    endtask

    // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 after retire.
    task automatic run_inst(input logic [15:0] ins, input int waits, input int idle,
                            input logic [15:0] mval);
        logic        is_c, need, last, take;
        logic [15:0] y, res;
        logic [14:0] nxt;
        for (int i = 0; i < idle; i++) begin
            bus.inst_valid = 1'b0;
            bus.inst = 16'($urandom);
            bus.m_ready = 1'($urandom);
            @(posedge clk); #1;
            check_idle("idle");
        end
        bus.in_m = mval;
        bus.inst = ins;
        bus.inst_valid = 1'b1;
        bus.m_ready = 1'($urandom);
        @(posedge clk); #1;
        bus.inst_valid = 1'($urandom);
        bus.inst = 16'($urandom);
        is_c = ins[15];
        need = is_c && (ins[12] || ins[3]);
        y = (is_c && ins[12]) ? mval : m_a;
        res = alu_f(m_d, y, is_c ? ins[11:6] : 6'd0);
        for (int k = 0; k <= waits; k++) begin
            last = !need || (k == waits);
            chk("exec_rdy", 32'(bus.inst_ready), 0);
            chk("exec_pc", 32'(bus.pc), 32'(m_pc));
            chk("exec_wr", 32'(bus.write_m), 32'(is_c && ins[3]));
            chk("exec_addr", 32'(bus.address_m), 32'(m_a[14:0]));
            chk("exec_x", 32'(bus.alu_x), 32'(m_d));
            chk("exec_y", 32'(bus.alu_y), 32'(y));
            chk("exec_ctl", 32'({bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no}),
                32'(is_c ? ins[11:6] : 6'd0));
            if (is_c) chk("exec_outm", 32'(bus.out_m), 32'(res));
            bus.m_ready = need ? last : 1'($urandom);
            @(posedge clk); #1;
            if (last) break;
        end
        if (!is_c) begin
            m_a = ins;
            m_pc = m_pc + 15'd1;
        end else begin
            take = (ins[2] && $signed(res) < 0) || (ins[1] && res == 16'h0) ||
                   (ins[0] && $signed(res) > 0);
            nxt = take ? m_a[14:0] : m_pc + 15'd1;
            if (ins[5]) m_a = res;
            if (ins[4]) m_d = res;
            m_pc = nxt;
        end
        check_idle("retire");
    endtask

    initial begin
        logic [15:0] ins;
        reset = 1'b1;
        bus.inst = 16'($urandom);
        bus.inst_valid = 1'b1;
        bus.in_m = 16'($urandom);
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        bus.inst = 16'($urandom);
        bus.in_m = 16'($urandom);
        bus.m_ready = 1'($urandom);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.inst_valid = 1'b0;
        m_a = 16'h0; m_d = 16'h0; m_pc = 15'h0;
        check_idle("reset");

        // Load D=5.
        run_inst(16'h0005, 0, 0, 16'h0);
        run_inst(16'hEC10, 2, 0, 16'h0);
        chk("load_d", 32'(bus.alu_x), 5);
        chk("load_d_pc", 32'(bus.pc), 2);

        // M=D at address 100 with three stall cycles.
        run_inst(16'h0064, 0, 1, 16'h0);
        run_inst(16'hE308, 3, 0, 16'h1234);
        chk("mwr_pc", 32'(bus.pc), 4);

        // Jumps.
        run_inst(16'hE301, 0, 0, 16'h0);
        chk("jgt_pc", 32'(bus.pc), 100);
        run_inst(16'h0000, 0, 0, 16'h0);
        run_inst(16'hEC10, 0, 0, 16'h0);
        run_inst(16'h1234, 0, 0, 16'h0);
        run_inst(16'hE302, 0, 0, 16'h0);
        chk("jeq_pc", 32'(bus.pc), 32'h1234);
        run_inst(16'hEE90, 0, 0, 16'h0);
        chk("dneg", 32'(bus.alu_x), 32'hFFFF);
        run_inst(16'hE301, 0, 0, 16'h0);
        chk("jgt_not", 32'(bus.pc), 32'h1236);
        run_inst(16'h0321, 0, 0, 16'h0);
        run_inst(16'hEA87, 0, 0, 16'h0);
        chk("jmp_pc", 32'(bus.pc), 32'h0321);

        // A=M, and A=M;JMP must jump to the old A.
        run_inst(16'h0007, 0, 0, 16'h0);
        run_inst(16'hFC20, 0, 0, 16'h0003);
        chk("a_from_m", 32'(bus.alu_y), 3);
        run_inst(16'h0007, 0, 0, 16'h0);
        run_inst(16'hFC27, 1, 0, 16'h0003);
        chk("a_from_m_jmp_pc", 32'(bus.pc), 7);
        chk("a_from_m_jmp_a", 32'(bus.address_m), 3);

        // D=0, then walk PC across the 15-bit wrap.
        run_inst(16'h0000, 0, 0, 16'h0);
        run_inst(16'hEC10, 0, 0, 16'h0);
        run_inst(16'h7FF0, 0, 0, 16'h0);
        run_inst(16'hEA87, 0, 0, 16'h0);
        for (int i = 0; i < 15; i++) run_inst(16'($urandom_range(0, 16'h7FFF)), 0, 0, 16'h0);
        chk("pc_top", 32'(bus.pc), 32'h7FFF);
        run_inst(16'h0042, 0, 0, 16'h0);
        chk("pc_wrap", 32'(bus.pc), 0);

        // Reset in the middle of a stalled M=D.
        bus.inst = 16'hE308;
        bus.inst_valid = 1'b1;
        @(posedge clk); #1;
        bus.inst_valid = 1'b0;
        bus.m_ready = 1'b0;
        chk("abort_wr0", 32'(bus.write_m), 1);
        @(posedge clk); #1;
        chk("abort_wr1", 32'(bus.write_m), 1);
        chk("abort_pc_hold", 32'(bus.pc), 0);
        reset = 1'b1;
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.m_ready = 1'b0;
        m_a = 16'h0; m_d = 16'h0; m_pc = 15'h0;
        check_idle("abort");

        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 1) == 0) ins = {1'b0, 15'($urandom)};
            else ins = {3'b111, 13'($urandom)};
            run_inst(ins, $urandom_range(0, 3), $urandom_range(0, 2), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/my_cpu_ctrl.md
# my_cpu_ctrl

Fetch/execute controller that drives the 16-bit combinational ALU in the Hack-style CPU. It decodes instructions, holds the A, D and PC registers, and supplies ALU operands and the six control bits. It consumes the ALU result and its zr/ng flags to write back results and resolve jumps. It also runs valid/ready handshakes toward instruction memory and data memory.

## Interface
Parameters: none (16-bit data, 15-bit addresses, fixed).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- inst  in  16  instruction word from instruction memory
- inst_valid  in  1  inst is valid this cycle
- inst_ready  out  1  controller can accept an instruction
- pc  out  15  address of the next instruction to fetch
- in_m  in  16  data-memory read data, combinational for address_m
- m_ready  in  1  data memory completes the current access this cycle
- address_m  out  15  data-memory address, always A[14:0]
- out_m  out  16  data-memory write data, equal to alu_out
- write_m  out  1  data-memory write request
- alu_x  out  16  ALU x operand
- alu_y  out  16  ALU y operand
- zx, nx, zy, ny, f, no  out  1 each  ALU control bits
- alu_out  in  16  ALU result, combinational from alu_x, alu_y and controls
- zr, ng  in  1 each  ALU zero and negative flags for alu_out

## Operation
- Registers: A (16), D (16), PC (15), IR (16), and a 1-bit state {FETCH, EXEC}.
- FETCH:
  - inst_ready=1.
  - When inst_valid, IR<=inst and go to EXEC.
  - Otherwise stay in FETCH.
- EXEC, A-instruction (IR[15]=0):
  - Retires unconditionally.
  - A<=IR zero-extended.
  - PC<=PC+1.
- EXEC, C-instruction (IR[15]=1). Fields:
  - IR[12]=a
  - IR[11:6]={zx,nx,zy,ny,f,no}
  - IR[5:3]={dA,dD,dM}
  - IR[2:0]={jlt,jeq,jgt}
- Operand and control drive for a C-instruction:
  - alu_x=D.
  - alu_y = a ? in_m : A.
  - Control bits come straight from IR.
- Memory access: the instruction needs memory if a=1 or dM=1. In that case it retires only in a cycle with m_ready=1. Otherwise it retires in its first EXEC cycle.
- write_m=dM for the whole EXEC period, including wait cycles.
- On the retire edge:
  - If dA, A<=alu_out.
  - If dD, D<=alu_out.
  - Jump condition: take = (jlt&ng) | (jeq&zr) | (jgt&~ng&~zr).
  - If take, PC<=A[14:0] using the A value before this edge. Otherwise PC<=PC+1.
  - State returns to FETCH.
- Outside EXEC of a C-instruction:
  - zx..no=0 and write_m=0.
  - alu_x=D and alu_y=A.
- PC arithmetic is modulo 2^15, so 0x7FFF+1 wraps to 0x0000.
- No other instruction is ever in flight; inst is ignored in EXEC.

## Timing
- Reset (synchronous): on the next edge, A=D=0, PC=0, IR=0, state=FETCH.
  - From that edge, inst_ready=1, write_m=0, zx..no=0, alu_x=alu_y=0, address_m=0, pc=0.
  - Reset wins over every concurrent event, including a handshake in FETCH and m_ready in EXEC.
  - Reset during an EXEC wait aborts the instruction: no register writeback, and write_m falls after that edge.
- Latency:
  - 2 cycles per instruction with no memory wait (accept edge, then retire edge).
  - 2+N cycles with N cycles of m_ready=0.
- inst_ready is asserted only in FETCH and is combinational from state.
- pc changes only on retire or reset edges.
- address_m, out_m and write_m are stable throughout an EXEC wait. in_m is sampled only on the retire edge (through alu_out).
- m_ready is ignored outside EXEC, and inside EXEC when no memory access is needed.

## Test plan
- Reset: hold reset 2 cycles with random inputs, then release. Required: pc=0, inst_ready=1, write_m=0, A=D=0.
- Load D: feed 0x0005 (A=5), then 0xEC10 (D=A). Required: each instruction retires 2 cycles after acceptance; D=5; pc=2.
- Memory write with wait: with D=5, feed 0x0064, then 0xE308 (M=D), holding m_ready=0 for 3 EXEC cycles.
  - Required: write_m=1, address_m=100, out_m=5, held steady for 4 cycles.
  - pc advances only on the m_ready edge.
- Jumps:
  - With A=100 and D=5, feed 0xE301 (D;JGT): pc=100.
  - With D=0, feed 0xE302 (D;JEQ): pc=A.
  - With D=0xFFFF, feed 0xE301: pc=old pc+1.
  - 0xEA87 (0;JMP): always pc=A.
- Compute into A from M: with A=7 and in_m=0x0003, feed 0xFC20 (A=M) with m_ready=1. Required: A=3; the jump target on the same edge uses the old A value.
- PC wrap and reset abort:
  - Run A-instructions until pc=0x7FFF; one more A-instruction gives pc=0.
  - Then assert reset during a stalled 0xE308. Required: write_m=0 after the edge, state FETCH, D unchanged at 0 after reset.
